// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch front end owning the PC, imem request and decode output slot
// Optional exception entry enabled by defining FETCH_EXC_VECTOR_EN (adds exc_valid).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_EXC_VECTOR_EN
    input  logic        exc_valid,
`endif
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);
    typedef enum logic {S_REQ, S_HOLD} state_t;
    state_t state, state_d;
    logic exc, flush, capture;
    logic [31:0] pc_d;
`ifdef FETCH_EXC_VECTOR_EN
    assign exc = exc_valid;
`else
    assign exc = 1'b0;
`endif
    assign imem_req = rst_n && state == S_REQ;
    always_comb begin
        flush   = exc || redirect_valid;
        capture = !flush && state == S_REQ && imem_ack && (!if_valid || id_ready);
        state_d = (!flush && if_valid && !id_ready) ? S_HOLD : S_REQ;
        pc_d    = exc ? EXC_VECTOR
                : redirect_valid ? (redirect_target & ~32'd3)
                : capture ? pc_plus4 : pc;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            if_valid <= !flush && (capture || (if_valid && !id_ready));
            if (capture) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed plus random checks of fetch_pc_unit against a behavioural model
module tb_fetch_pc_unit;
    logic clk = 0, rst_n = 0, imem_ack = 0, redirect_valid = 0, id_ready = 0, exc_valid = 0;
    logic [31:0] imem_rdata = 0, redirect_target = 0, pc, pc_plus4, if_instr, if_pc;
    logic imem_req, if_valid;
    int total = 0, bad = 0;
    logic [31:0] m_pc, m_instr, m_ipc, s_instr, s_pc;
    logic m_valid, m_hold;

    always #5 clk = ~clk;
    assign pc_plus4 = pc + 32'd4;

    fetch_pc_unit dut (
        .clk(clk), .rst_n(rst_n),
`ifdef FETCH_EXC_VECTOR_EN
        .exc_valid(exc_valid),
`endif
        .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the fetch rules, compare after the edge.
    task automatic step(input logic r, input logic a, input logic [31:0] d, input logic rv,
                        input logic [31:0] t, input logic rdy, input logic ex);
        logic room, fetched;
        rst_n = r; imem_ack = a; imem_rdata = d; redirect_valid = rv;
        redirect_target = t; id_ready = rdy; exc_valid = ex;
        if (!r) begin
            m_pc = 32'h0; m_valid = 0; m_instr = 0; m_ipc = 0; m_hold = 0;
        end else if (ex) begin
            m_pc = 32'h180; m_valid = 0; m_hold = 0;
        end else if (rv) begin
            m_pc = {t[31:2], 2'b00}; m_valid = 0; m_hold = 0;
        end else begin
            room = !m_valid || rdy;
            fetched = !m_hold && a && room;
            m_hold = m_valid && !rdy;
            if (fetched) begin
                m_instr = d; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
            end else if (m_valid && rdy) m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("pc", pc, m_pc);
        chk("imem_req", {31'b0, imem_req}, {31'b0, r && !m_hold});
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_ipc);
    endtask

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_req", {31'b0, imem_req}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'hA000_0000 + i, 0, 0, 1, 0);
            chk("stream_if_pc", if_pc, 32'(i * 4));
            chk("stream_valid", {31'b0, if_valid}, 32'h1);
        end
        s_instr = if_instr; s_pc = if_pc;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'hDEAD_0000 + i, 0, 0, 0, 0);
            chk("stall_instr", if_instr, s_instr);
            chk("stall_pc", if_pc, s_pc);
            chk("stall_req", {31'b0, imem_req}, 32'h0);
            chk("stall_pcreg", pc, 32'h10);
        end
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 32'h1111_2222, 0, 0, 1, 0);
        chk("resume_pc", if_pc, 32'h10);
        step(1, 1, 32'h3333_4444, 1, 32'h0000_0103, 1, 0);
        chk("redir_valid", {31'b0, if_valid}, 32'h0);
        chk("redir_pc", pc, 32'h100);
        step(1, 1, 32'h5555_6666, 0, 0, 1, 0);
        chk("redir_if_pc", if_pc, 32'h100);
        step(1, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
        step(1, 1, 32'h7777_8888, 0, 0, 1, 0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        step(1, 1, 32'h9999_AAAA, 0, 0, 1, 0);
        step(0, 1, 32'hBBBB_CCCC, 0, 0, 1, 0);
        chk("rst_mid_pc", pc, 32'h0);
        chk("rst_mid_valid", {31'b0, if_valid}, 32'h0);
`ifdef FETCH_EXC_VECTOR_EN
        step(1, 1, 32'h1234_5678, 0, 0, 1, 0);
        step(1, 1, 32'h1234_5679, 1, 32'h0000_0400, 1, 1);
        chk("exc_pc", pc, 32'h180);
        chk("exc_valid", {31'b0, if_valid}, 32'h0);
`endif
        for (int i = 0; i < 400; i++) begin
            logic ex;
`ifdef FETCH_EXC_VECTOR_EN
            ex = ($urandom_range(0, 29) == 0);
`else
            ex = 1'b0;
`endif
            step($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0, $urandom,
                 $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 2) != 0, ex);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
